// File: rtl/scratch_stack_arbiter_pkg.sv
// Shared definitions for the scratch-stack controller: op codes, FSM states,
// default geometry.
package scratch_stack_arbiter_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RDW  = 3'd3,
        ST_ACK  = 3'd4
    } state_e;

endpackage

// File: rtl/scratch_stack_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter. Grant is combinational and one-hot; the
// last-granted port is remembered so a tie goes to the other port.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic [1:0] o_grant
);

    logic r_last;   // 1 = port 1 was granted most recently

    // Pick a winner: lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        o_grant = 2'b00;
        if (i_req == 2'b11)
            o_grant = r_last ? 2'b01 : 2'b10;
        else
            o_grant = i_req;
    end

    // Remember who won, only when the parent actually commits a grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_last <= 1'b1;
        else if (i_grant_en && (|i_req))
            r_last <= o_grant[1];
    end

endmodule

// File: rtl/scratch_stack_arbiter.sv
// Scratch-stack controller: owns the stack pointer, sequences the single-port
// registered-read RAM, and shares it between two req/ack requesters.
module scratch_stack_arbiter
    import scratch_stack_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              r0_req,
    input  logic [1:0]        r0_op,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic [1:0]        r1_op,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   depth,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH_MAX = (ADDR_W+1)'(1) << ADDR_W;

    state_e              r_state;
    logic                r_port;     // granted port for the transaction in flight
    op_e                 r_op;
    logic                r_err;
    logic [ADDR_W:0]     r_depth;
    logic [DATA_W-1:0]   r_rd_buf;   // read word parked until the ack edge

    logic [1:0]          w_grant;
    logic                w_grant_en;
    logic                w_sel;
    op_e                 w_op;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_full;
    logic                w_empty;

    // No new grant while an ack is on the wire, so a requester dropping req
    // in response to ack is never mistaken for a fresh request.
    assign w_grant_en = (r_state == ST_IDLE) && !(r0_ack || r1_ack);
    assign w_sel      = w_grant[1];
    assign w_op       = w_grant[0] ? op_e'(r0_op) : op_e'(r1_op);
    assign w_wdata    = w_grant[0] ? r0_wdata : r1_wdata;

    assign w_full  = (r_depth == DEPTH_MAX);
    assign w_empty = (r_depth == '0);
    assign depth   = r_depth;
    assign full    = w_full;
    assign empty   = w_empty;

    rr_arbiter_2 u_arb (
        .clk        (clk),
        .resetn     (resetn),
        .i_req      ({r1_req, r0_req}),
        .i_grant_en (w_grant_en),
        .o_grant    (w_grant)
    );

    // Transaction FSM with all RAM drive and requester outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_port    <= 1'b0;
            r_op      <= OP_PUSH;
            r_err     <= 1'b0;
            r_depth   <= '0;
            r_rd_buf  <= '0;
            ram_addr  <= '0;
            ram_wen   <= 1'b0;
            ram_wdata <= '0;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
            r0_err    <= 1'b0;
            r1_err    <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            r0_err <= 1'b0;
            r1_err <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant_en && (|w_grant)) begin
                        r_port <= w_sel;
                        r_op   <= w_op;
                        r_err  <= 1'b0;
                        unique case (w_op)
                            OP_PUSH: begin
                                if (w_full) begin
                                    r_err   <= 1'b1;
                                    r_state <= ST_ACK;
                                end else begin
                                    ram_addr  <= r_depth[ADDR_W-1:0];
                                    ram_wdata <= w_wdata;
                                    ram_wen   <= 1'b1;
                                    r_state   <= ST_WR;
                                end
                            end
                            OP_POP, OP_PEEK: begin
                                if (w_empty) begin
                                    r_err   <= 1'b1;
                                    r_state <= ST_ACK;
                                end else begin
                                    // Low bits wrap correctly even when depth is at its maximum.
                                    ram_addr <= r_depth[ADDR_W-1:0] - ADDR_W'(1);
                                    r_state  <= ST_RD;
                                end
                            end
                            OP_CLEAR: begin
                                r_depth <= '0;
                                r_state <= ST_ACK;
                            end
                            default: r_state <= ST_ACK;
                        endcase
                    end
                end
                ST_WR: begin
                    ram_wen <= 1'b0;
                    r_depth <= r_depth + (ADDR_W+1)'(1);
                    r_state <= ST_ACK;
                end
                ST_RD: begin
                    // RAM registers ram_addr on this edge; data appears next cycle.
                    r_state <= ST_RDW;
                end
                ST_RDW: begin
                    r_rd_buf <= ram_rdata;
                    if (r_op == OP_POP)
                        r_depth <= r_depth - (ADDR_W+1)'(1);
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    if (r_port) begin
                        r1_ack <= 1'b1;
                        r1_err <= r_err;
                        if (!r_err && (r_op == OP_POP || r_op == OP_PEEK))
                            r1_rdata <= r_rd_buf;
                    end else begin
                        r0_ack <= 1'b1;
                        r0_err <= r_err;
                        if (!r_err && (r_op == OP_POP || r_op == OP_PEEK))
                            r0_rdata <= r_rd_buf;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
